// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB transaction arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } arb_path_t;

  localparam int DEFAULT_LEN_WIDTH = 4;

endpackage

// File: rtl/apb_txn_arbiter_rr_arb2.sv
// Two-requester round-robin pick; last_gnt advances only when a grant is issued.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_wr_i,
  input  logic req_rd_i,
  input  logic upd_i,
  input  logic upd_path_i,
  output logic pick_o,
  output logic any_o
);

  arb_path_t last_gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= RD;
    end else if (upd_i) begin
      last_gnt_q <= arb_path_t'(upd_path_i);
    end
  end

  always_comb begin
    pick_o = WR;
    if (req_wr_i && req_rd_i) begin
      pick_o = (last_gnt_q == RD) ? WR : RD;
    end else if (req_rd_i) begin
      pick_o = RD;
    end
  end

  assign any_o = req_wr_i | req_rd_i;

endmodule

// File: rtl/apb_txn_arbiter.sv
// Shares one APB handler between the AXI write and read request paths.
// Optional watchdog on missing beats: define APB_ARB_TIMEOUT_EN.
module apb_txn_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LEN_WIDTH      = DEFAULT_LEN_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [LEN_WIDTH-1:0]  wr_len_i,
  output logic                  wr_gnt_o,
  output logic                  wr_done_o,
  output logic                  wr_err_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [LEN_WIDTH-1:0]  rd_len_i,
  output logic                  rd_gnt_o,
  output logic                  rd_done_o,
  output logic                  rd_err_o,
  output logic                  wr_trans_o,
  output logic                  rd_trans_o,
  output logic [ADDR_WIDTH-1:0] trans_addr_o,
  output logic [LEN_WIDTH-1:0]  burst_len_o,
  input  logic                  trans_done_i,
  input  logic                  trans_error_i,
  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  localparam int CW  = LEN_WIDTH + 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  arb_state_t            state_q, state_d;
  arb_path_t             owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [WDW-1:0]        wdog_q, wdog_d;
  logic                  done_q;
  logic                  beat;
  logic                  pick, any_req, arb_upd;

  rr_arb2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req_wr_i   (wr_req_i),
    .req_rd_i   (rd_req_i),
    .upd_i      (arb_upd),
    .upd_path_i (owner_q),
    .pick_o     (pick),
    .any_o      (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= WR;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
      done_q  <= trans_done_i;
    end
  end

  // A held-high trans_done_i is one beat: only its rising edge counts.
  assign beat = trans_done_i & ~done_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    arb_upd = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        err_d  = 1'b0;
        wdog_d = '0;
        if (any_req) begin
          owner_d = arb_path_t'(pick);
          addr_d  = (pick == RD) ? rd_addr_i : wr_addr_i;
          len_d   = (pick == RD) ? rd_len_i : wr_len_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        arb_upd = 1'b1;
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (beat) begin
          cnt_d  = cnt_q + CW'(1);
          err_d  = err_q | trans_error_i;
          wdog_d = '0;
          if ((cnt_q + CW'(1)) == ({1'b0, len_q} + CW'(1))) begin
            state_d = RESP;
          end
        end else if (TIMEOUT_EN) begin
          wdog_d = wdog_q + WDW'(1);
          if ((wdog_q + WDW'(1)) == WDW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        addr_d  = '0;
        len_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_gnt_o     = (state_q == ISSUE) && (owner_q == WR);
  assign rd_gnt_o     = (state_q == ISSUE) && (owner_q == RD);
  assign wr_trans_o   = wr_gnt_o;
  assign rd_trans_o   = rd_gnt_o;
  assign wr_done_o    = (state_q == RESP) && (owner_q == WR);
  assign rd_done_o    = (state_q == RESP) && (owner_q == RD);
  assign wr_err_o     = wr_done_o & err_q;
  assign rd_err_o     = rd_done_o & err_q;
  assign trans_addr_o = addr_q;
  assign burst_len_o  = len_q;
  assign busy_o       = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule
